sign_extend: RTL and testbench
==============================

// Module: sign_extend
// PURPOSE
//   Registered immediate extender for the CPU decode stage. Takes an IN_W-bit
//   instruction immediate and produces an OUT_W-bit two's-complement sign-extended
//   value for the ALU operand mux and the branch-offset adder.
//   One-cycle pipelined; the valid flag travels with the data.
// PARAMETERS
//   IN_W   8   width of Immediate; must be >= 2
//   OUT_W  16  width of SignExtImmediate; must be >= IN_W (elaboration $error otherwise)
// PORTS
//   clk               input   1      single clock; all state on rising edge
//   rst               input   1      synchronous, active-high reset
//   in_valid          input   1      Immediate is valid this cycle
//   Immediate         input   IN_W   raw immediate field
//   zext              input   1      only with SIGN_EXTEND_ZEXT_EN: 1 = zero-extend
//   out_valid         output  1      SignExtImmediate holds a result
//   SignExtImmediate  output  OUT_W  extended immediate
// BEHAVIOUR
//   - Reset (rst=1 at a rising clk edge): out_valid<=0, SignExtImmediate<=0.
//     rst has priority over in_valid in the same cycle. A value captured in the
//     cycle rst is asserted is discarded.
//   - Latency: exactly 1 cycle. If in_valid=1 at edge N, then after edge N:
//       SignExtImmediate = {{(OUT_W-IN_W){Immediate[IN_W-1]}}, Immediate}
//       out_valid = 1
//   - in_valid=0 at an edge: out_valid<=0 and SignExtImmediate holds its last value
//     (no data-path toggling).
//   - No backpressure. A new input is accepted every cycle, giving full throughput.
//   - Low IN_W bits pass through unchanged. Upper bits replicate bit IN_W-1.
//     OUT_W==IN_W degenerates to a register.
//   - Purely bitwise; no arithmetic, overflow or saturation.
//   - X on Immediate with in_valid=1 propagates. X on in_valid is not permitted
//     (assertion in simulation).
// CONFIGURATION
//   SIGN_EXTEND_ZEXT_EN defined:
//     - Port zext exists and is sampled with Immediate.
//     - zext=1 makes the upper OUT_W-IN_W bits 0 (used for logical immediates).
//     - zext=0 sign-extends.
//   SIGN_EXTEND_ZEXT_EN undefined:
//     - Port zext is absent; the block always sign-extends.
// STRUCTURE
//   - sign_extend_pkg holds:
//       localparam IMM_W_DEFAULT=8 and EXT_W_DEFAULT=16
//       typedef enum logic {EXT_SIGN, EXT_ZERO} ext_mode_e
//   - Sub-module sign_extend_core: combinational extender (Immediate, mode -> extended
//     value). sign_extend wraps it with the output register and the valid flop.
// TESTING
//   - Reset: hold rst=1 for 2 edges with in_valid=1, Immediate=8'hFF.
//     Expect out_valid=0 and SignExtImmediate=16'h0000.
//   - Positive value: Immediate=8'b00001011 (0x0B) with in_valid.
//     Expect 16'h000B and out_valid=1 one cycle later.
//   - Negative value: Immediate=8'b10010100 (0x94). Expect 16'hFF94.
//     Then 8'h80 -> 16'hFF80 and 8'hFF -> 16'hFFFF.
//   - MSB clear: Immediate=8'b01110010 (0x72). Expect 16'h0072; 8'h7F -> 16'h007F.
//   - Back-to-back inputs 0x0B, 0x94, 0x72 on consecutive cycles give
//     0x000B, 0xFF94, 0x0072 on consecutive cycles.
//     Then drop in_valid: out_valid falls and the data holds 0x0072.
//   - With SIGN_EXTEND_ZEXT_EN: zext=1 with 0x94 -> 16'h0094; zext=0 -> 16'hFF94.
//     Assert rst mid-stream: the next output is 0 with out_valid=0.

Source files
------------

// File: rtl/sign_extend_pkg.sv
// rtl/sign_extend_pkg.sv - shared widths and extension-mode type for the immediate extender
//
// Purpose:
//   Default widths for the decode-stage immediate extender and the enum
//   that selects between sign and zero extension.
// Contents:
//   IMM_W_DEFAULT  default raw immediate width
//   EXT_W_DEFAULT  default extended immediate width
//   ext_mode_e     EXT_SIGN replicates the immediate MSB, EXT_ZERO fills with 0
package sign_extend_pkg;

  localparam int IMM_W_DEFAULT = 8;
  localparam int EXT_W_DEFAULT = 16;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_mode_e;

endpackage

// File: rtl/sign_extend_core.sv
// rtl/sign_extend_core.sv - combinational immediate extender (sign or zero fill)
//
// Purpose:
//   Widens an IN_W-bit immediate to OUT_W bits. The low IN_W bits pass
//   through unchanged; the upper bits are either copies of bit IN_W-1
//   (EXT_SIGN) or zero (EXT_ZERO). Purely bitwise, no arithmetic.
// Ports:
//   imm   input  IN_W   raw immediate
//   mode  input  1      ext_mode_e extension selector
//   ext   output OUT_W  extended immediate
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W_DEFAULT,
  parameter int OUT_W = EXT_W_DEFAULT
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_e        mode,
  output logic [OUT_W-1:0] ext
);

  // A zero-width replication is illegal, so the equal-width case is a
  // separate branch where the extender collapses to a wire.
  if (OUT_W > IN_W) begin : g_ext
    logic fill;
    assign fill = (mode == EXT_SIGN) ? imm[IN_W-1] : 1'b0;
    assign ext  = {{(OUT_W-IN_W){fill}}, imm};
  end else begin : g_pass
    logic unused_mode;
    assign unused_mode = mode;
    assign ext         = imm;
  end

endmodule

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - registered immediate extender for the CPU decode stage
//
// Purpose:
//   One-cycle pipelined immediate extender feeding the ALU operand mux and
//   the branch-offset adder. The valid flag travels with the data; a new
//   immediate is accepted every cycle and there is no backpressure.
//   Optional feature macro: SIGN_EXTEND_ZEXT_EN adds the zext port, which
//   selects zero extension for logical immediates. Without it the block
//   always sign-extends.
// Ports:
//   clk               input  1      clock, all state on rising edge
//   rst               input  1      synchronous active-high reset
//   in_valid          input  1      Immediate is valid this cycle
//   Immediate         input  IN_W   raw immediate field
//   zext              input  1      (SIGN_EXTEND_ZEXT_EN only) 1 = zero-extend
//   out_valid         output 1      SignExtImmediate holds a result
//   SignExtImmediate  output OUT_W  extended immediate
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W_DEFAULT,
  parameter int OUT_W = EXT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  Immediate,
`ifdef SIGN_EXTEND_ZEXT_EN
  input  logic             zext,
`endif
  output logic             out_valid,
  output logic [OUT_W-1:0] SignExtImmediate
);

  if (IN_W < 2 || OUT_W < IN_W) begin : g_bad_params
    $error("sign_extend: need IN_W >= 2 and OUT_W >= IN_W (IN_W=%0d OUT_W=%0d)", IN_W, OUT_W);
  end

  ext_mode_e        mode;
  logic [OUT_W-1:0] ext_value;

`ifdef SIGN_EXTEND_ZEXT_EN
  assign mode = zext ? EXT_ZERO : EXT_SIGN;
`else
  assign mode = EXT_SIGN;
`endif

  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (Immediate),
    .mode (mode),
    .ext  (ext_value)
  );

  // Data only loads on a valid input so the output bus stays quiet while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      SignExtImmediate <= '0;
    end else if (in_valid) begin
      out_valid        <= 1'b1;
      SignExtImmediate <= ext_value;
    end else begin
      out_valid        <= 1'b0;
    end
  end

  a_in_valid_known: assert property (@(posedge clk) !$isunknown(in_valid))
    else $error("sign_extend: in_valid is X/Z");

endmodule

// File: tb/tb_sign_extend.sv
// tb/tb_sign_extend.sv - directed self-checking bench for sign_extend
module tb_sign_extend;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  imm;
  logic        zext;
  logic        out_valid;
  logic [15:0] ext_imm;

  int total;
  int bad;

  sign_extend #(
    .IN_W  (8),
    .OUT_W (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .Immediate        (imm),
`ifdef SIGN_EXTEND_ZEXT_EN
    .zext             (zext),
`endif
    .out_valid        (out_valid),
    .SignExtImmediate (ext_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present inputs, let one rising edge capture them, then settle away from the edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic z);
    in_valid = v;
    imm      = d;
    zext     = z;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  vec_in  [6];
  logic [15:0] vec_exp [6];
  logic [7:0]  b2b_in  [3];
  logic [15:0] b2b_exp [3];

  initial begin
    total = 0;
    bad   = 0;

    vec_in  = '{8'h0B,    8'h94,    8'h80,    8'hFF,    8'h72,    8'h7F};
    vec_exp = '{16'h000B, 16'hFF94, 16'hFF80, 16'hFFFF, 16'h0072, 16'h007F};
    b2b_in  = '{8'h0B,    8'h94,    8'h72};
    b2b_exp = '{16'h000B, 16'hFF94, 16'h0072};

    // Reset held for two edges while a valid input is presented.
    rst = 1'b1;
    in_valid = 1'b1;
    imm = 8'hFF;
    zext = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    check("reset_data", ext_imm, 16'h0000);
    rst = 1'b0;

    // Single vectors, each followed by an idle cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vec_in[i], 1'b0);
      check($sformatf("vec%0d_data", i), ext_imm, vec_exp[i]);
      check($sformatf("vec%0d_valid", i), {15'd0, out_valid}, 16'd1);
      drive(1'b0, 8'h00, 1'b0);
      check($sformatf("vec%0d_idle_valid", i), {15'd0, out_valid}, 16'd0);
    end

    // Back-to-back inputs on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b2b_in[i], 1'b0);
      check($sformatf("b2b%0d_data", i), ext_imm, b2b_exp[i]);
      check($sformatf("b2b%0d_valid", i), {15'd0, out_valid}, 16'd1);
    end

    // Dropping in_valid clears out_valid and holds the data, even with a new Immediate.
    drive(1'b0, 8'hAA, 1'b0);
    check("drop_valid", {15'd0, out_valid}, 16'd0);
    check("drop_hold", ext_imm, 16'h0072);
    drive(1'b0, 8'h80, 1'b0);
    check("hold2_data", ext_imm, 16'h0072);

`ifdef SIGN_EXTEND_ZEXT_EN
    drive(1'b1, 8'h94, 1'b1);
    check("zext1_data", ext_imm, 16'h0094);
    check("zext1_valid", {15'd0, out_valid}, 16'd1);
    drive(1'b1, 8'h94, 1'b0);
    check("zext0_data", ext_imm, 16'hFF94);
    drive(1'b1, 8'hFF, 1'b1);
    check("zext1_ff", ext_imm, 16'h00FF);
`endif

    // Reset mid-stream: the value presented alongside rst is discarded.
    drive(1'b1, 8'h7F, 1'b0);
    check("pre_rst_data", ext_imm, 16'h007F);
    rst = 1'b1;
    drive(1'b1, 8'h94, 1'b0);
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_data", ext_imm, 16'h0000);
    rst = 1'b0;
    drive(1'b1, 8'h01, 1'b0);
    check("post_rst_data", ext_imm, 16'h0001);
    check("post_rst_valid", {15'd0, out_valid}, 16'd1);
    drive(1'b1, 8'hC3, 1'b0);
    check("post_rst_neg", ext_imm, 16'hFFC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
